// File: rtl/debounce_pulse.sv
// ----------------------------------------------------------------------------
// debounce_pulse
//
// Purpose:
//   Debounces a raw, asynchronous, active-high push-button and produces:
//     - a single-cycle strobe for every accepted press (drives the d input of a
//       downstream toggle stage),
//     - a registered debounced level,
//     - a registered enable for the toggle stage. The enable is low throughout
//       reset so that stage is held clear.
//
//   Optional feature, selected by the macro LONG_PRESS_EN:
//     When the macro is defined, holding a debounced press for LONG_CYCLES
//     cycles drops en_out for exactly one cycle, which clears the toggle stage.
//     This fires at most once per press. When the macro is undefined, there is
//     no hold counter, and en_out is constantly 1 once reset has been released.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed (2..65535)
//   LONG_CYCLES      hold time before the long-press clear (2..2^20-1)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_in       in   raw bouncing button level
//   pulse        out  one-cycle strobe per accepted press
//   en_out       out  toggle-stage enable (0 clears that stage)
//   stable       out  debounced button level
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: none. pulse is a qualifier-free strobe. A consumer samples it on
// any rising clk edge, and it is high for exactly one of those edges.
// ----------------------------------------------------------------------------
module debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       pulse,
  output logic       en_out,
  output logic       stable,
  output logic [1:0] dbg_state_o
);

  // Reject illegal parameter values at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("debounce_pulse: DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES < 2 || LONG_CYCLES > 1048575) begin : g_bad_long
    $error("debounce_pulse: LONG_CYCLES out of range");
  end

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer. Only q2 ("sync") is used by the logic below.
  // --------------------------------------------------------------------------
  logic q1_q, q2_q;
  logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q1_q <= btn_in;
      q2_q <= q1_q;
    end
  end

  assign sync = q2_q;

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            stable_q, stable_d;
  logic            en_q, en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          // A bounce aborts the wait, and no output changes.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          // The button is still held, so the press resumes without a new strobe.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The debounced level follows the state that is being entered, so it
  // changes on the same edge as the state.
  assign stable_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

`ifdef LONG_PRESS_EN
  // --------------------------------------------------------------------------
  // Long-press clear. The hold counter saturates at LONG_CYCLES and counts
  // while the debounced level is high. The fired flag limits the clear to one
  // per press. Both the counter and the flag clear in IDLE.
  // --------------------------------------------------------------------------
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          fired_q, fired_d;
  logic          long_fire;

  always_comb begin
    hold_d    = hold_q;
    fired_d   = fired_q;
    long_fire = 1'b0;
    if (state_q == IDLE) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
      end
    end
    // The clear fires on the edge where the counter reaches LONG_CYCLES.
    if (hold_d == HOLD_MAX && !fired_q) begin
      long_fire = 1'b1;
      fired_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
    end
  end

  assign en_d = !long_fire;
`else
  assign en_d = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State and output registers. en_out resets low and rises on the first
  // edge after reset is released.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      stable_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      stable_q <= stable_d;
      en_q     <= en_d;
    end
  end

  assign pulse       = pulse_q;
  assign stable      = stable_q;
  assign en_out      = en_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter LONG_CYCLES, default 1000, cycles a debounced press must be held before the long-press clear fires; legal range 2..2^20-1.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port btn_in  input  1  raw, asynchronous, bouncing button level; active-high.
REQ-006 Port pulse  output  1  registered one-cycle strobe per accepted press; drives the toggle stage's d input.
REQ-007 Port en_out  output  1  registered enable for the toggle stage; 0 clears that stage.
REQ-008 Port stable  output  1  registered debounced button level.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer (q1, q2); only q2 ("sync") feeds the logic.
REQ-010 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with debounce counter cnt sized to hold DEBOUNCE_CYCLES.
REQ-011 IDLE: sync=1 -> PRESS_WAIT, cnt=1; otherwise stay, cnt=0.
REQ-012 PRESS_WAIT: sync=0 -> IDLE, cnt=0; else if cnt==DEBOUNCE_CYCLES -> PRESSED, cnt=0, pulse=1; else cnt+1.
REQ-013 PRESSED: sync=0 -> RELEASE_WAIT, cnt=1; otherwise stay.
REQ-014 RELEASE_WAIT: sync=1 -> PRESSED, cnt=0, no pulse; else if cnt==DEBOUNCE_CYCLES -> IDLE, cnt=0; else cnt+1.
REQ-015 pulse SHALL be high for exactly one cycle, only on the PRESS_WAIT->PRESSED transition, and never on RELEASE_WAIT->PRESSED.
REQ-016 Latency: with btn_in high and stable before edge k, pulse SHALL rise after edge k+DEBOUNCE_CYCLES+2 and fall after the next edge.
REQ-017 stable SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT, updated on the same edge as the state.
REQ-018 A bounce that returns sync before cnt reaches DEBOUNCE_CYCLES SHALL abort the wait with no output change.
REQ-019 en_out SHALL be 1 in normal operation except as defined by REQ-025.

Reset
REQ-020 rst_n=0 SHALL immediately force: q1=q2=0, state=IDLE, cnt=0, pulse=0, stable=0, en_out=0, hold counter=0, long-fired flag=0.
REQ-021 en_out SHALL return to 1 on the first rising clk edge after rst_n deasserts, so the downstream toggle stage is cleared throughout reset.
REQ-022 Reset asserted mid-debounce or mid-press SHALL discard all progress; no pulse SHALL be emitted for that press after release of reset unless it is re-debounced from IDLE.

Configuration
REQ-023 Macro LONG_PRESS_EN SHALL compile the long-press clear feature in or out.
REQ-024 With LONG_PRESS_EN defined: a saturating hold counter SHALL increment each cycle in PRESSED or RELEASE_WAIT and clear in IDLE; a long-fired flag SHALL clear in IDLE.
REQ-025 With LONG_PRESS_EN defined: when the hold counter reaches LONG_CYCLES and the flag is 0, en_out SHALL be 0 for exactly one cycle and the flag SHALL set, so it fires at most once per press.
REQ-026 Without LONG_PRESS_EN: no hold counter or flag SHALL exist, and en_out SHALL be 1 at all times outside REQ-020/REQ-021.

Verification
REQ-027 Reset release: DEBOUNCE_CYCLES=4, btn_in=0 -> en_out=0 during reset and 1 after the first edge; pulse=0 and stable=0 throughout.
REQ-028 Clean press: DEBOUNCE_CYCLES=4, btn_in=1 before edge 0 -> pulse=1 only between edges 6 and 7; stable=1 from edge 6.
REQ-029 Press bounce: DEBOUNCE_CYCLES=4, btn_in toggles 1,0,1,0 every 2 cycles and then stays high -> exactly one pulse, 6 edges after the final rising level is sampled.
REQ-030 Release bounce: while PRESSED, sync low for 2 cycles then high -> no pulse and stable stays 1; after 4 further low cycles plus sync delay, stable=0.
REQ-031 Long press (LONG_PRESS_EN, DEBOUNCE_CYCLES=4, LONG_CYCLES=10): hold btn_in for 40 cycles -> one pulse, then en_out=0 for exactly one cycle, 10 edges after entering PRESSED, and never again that press; without the macro, en_out stays 1.
REQ-032 Async reset mid-PRESS_WAIT (cnt=3): assert rst_n=0 between edges -> all outputs take their reset values at once with no clock, and no pulse occurs until a fresh full debounce completes.
